if_fetch_stage: RTL
===================

# if_fetch_stage

Instruction-fetch stage of the 5-stage MIPS pipeline: owns the PC register, issues one-outstanding-request fetches to instruction memory, and drives the IF/ID pipeline register. Consumes the PC/IF-ID stall signals from the hazard detection unit and the branch flush/target from ID. Buffers a returning instruction while the pipeline is stalled so no fetch is lost or repeated.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- clk_i  in  1  pipeline clock
- rst_i  in  1  synchronous, active-high reset
- PC_stall_i  in  1  hold PC (from hazard unit)
- IFID_stall_i  in  1  hold IF/ID contents (from hazard unit)
- flush_i  in  1  branch taken in ID; redirect and bubble IF/ID
- branch_target_i  in  32  redirect address, valid with flush_i
- imem_req_o  out  1  fetch request, one-cycle pulse
- imem_addr_o  out  32  fetch address, valid with imem_req_o
- imem_ready_i  in  1  response strobe, ≥1 cycle after request
- imem_data_i  in  32  instruction word, valid with imem_ready_i
- pc_o  out  32  current PC register
- IFID_pc_o  out  32  PC+4 of instruction in IF/ID
- IFID_inst_o  out  32  instruction in IF/ID (32'h0 = nop when bubble)
- IFID_valid_o  out  1  IF/ID holds a real instruction
- fetch_cnt_o, stall_cnt_o  out  32 each  perf counters (see Configuration)

## Operation
- States: BOOT, ISSUE, WAIT, HOLD. Reset → BOOT; BOOT → ISSUE unconditionally.
- "hold" = PC_stall_i | IFID_stall_i.
- ISSUE: imem_req_o=1, imem_addr_o=pc; → WAIT. If flush_i: set discard flag, pc←branch_target_i.
- WAIT: imem_req_o=0. On imem_ready_i:
  - discard set or flush_i: drop data, clear discard, pc←branch_target_i if flush_i; → ISSUE.
  - else !hold: IF/ID←{pc+4, data, valid=1}; pc←pc+4; → ISSUE.
  - else: buffer←data; → HOLD.
  - flush_i without imem_ready_i: set discard, pc←branch_target_i, stay WAIT.
- HOLD: flush_i → drop buffer, pc←branch_target_i, → ISSUE. Else !hold → IF/ID←{pc+4, buffer, 1}, pc←pc+4, → ISSUE. Else stay.
- IF/ID update priority: rst_i > flush_i (bubble) > IFID_stall_i (hold all fields) > new instruction load > bubble (valid=0, inst=0, pc field unchanged).
- PC changes only via flush or instruction delivery; PC_stall_i blocks delivery, never a flush.
- PC arithmetic modulo 2^32; 32'hFFFF_FFFC+4 wraps to 0.
- imem_ready_i outside WAIT is ignored.

## Timing
- Reset values: pc_o=RESET_PC; IFID_pc_o=0, IFID_inst_o=0, IFID_valid_o=0; imem_req_o=0; imem_addr_o=RESET_PC; counters 0; discard=0; state BOOT.
- First request the cycle after rst_i deasserts.
- imem_req_o, imem_addr_o decoded from state/pc registers (no comb path from inputs).
- 1-cycle memory: ISSUE at t, ready at t+1, IF/ID valid at t+2; peak 1 instruction per 2 cycles.
- Reset mid-fetch: outstanding response after reset is ignored (state BOOT/ISSUE).
- flush_i and hold in same cycle: flush wins; IF/ID bubbled.

## Configuration
- FETCH_PERF_CNT_EN defined: fetch_cnt_o increments on each IF/ID load with valid=1; stall_cnt_o increments each cycle with hold=1 in any state; both wrap at 2^32, cleared by rst_i.
- Undefined: counter registers not instantiated; both outputs constant 0.

## Test plan
- Reset with RESET_PC=32'h100, 1-cycle memory returning addr as data -> requests 0x100,0x104,0x108 every 2 cycles; IF/ID shows inst 0x100 with IFID_pc_o=0x104.
- Hold 3 cycles while response for 0x104 arrives -> HOLD; IF/ID keeps 0x100; on release IF/ID=0x104 once, next request 0x108, no duplicate fetch.
- flush_i with target 0x200 while WAIT (3-cycle memory) -> stale response dropped, next request 0x200, IF/ID bubble (valid=0, inst=0).
- flush_i in same cycle as imem_ready_i and hold=1 -> data dropped, pc_o=0x200, IF/ID bubbled.
- pc=32'hFFFF_FFFC delivery -> pc_o=0, IFID_pc_o=0.
- With FETCH_PERF_CNT_EN, 10 deliveries and 4 hold cycles -> fetch_cnt_o=10, stall_cnt_o=4; without macro both read 0.

Source files
------------

// File: rtl/if_fetch_stage.sv
// ---------------------------------------------------------------------------
// if_fetch_stage
//   Instruction-fetch stage of the 5-stage MIPS pipeline. It owns the PC,
//   keeps at most one instruction-memory request outstanding, and drives the
//   IF/ID pipeline register. If the response arrives while the pipeline is
//   stalled, the word is parked in a one-entry buffer, so a fetch is never
//   lost or repeated.
//
// Parameters
//   RESET_PC        PC value loaded on reset
//
// Ports
//   clk_i, rst_i        clock, synchronous active-high reset
//   PC_stall_i          hold PC (hazard unit)
//   IFID_stall_i        hold IF/ID contents (hazard unit)
//   flush_i             branch taken in ID: redirect and bubble IF/ID
//   branch_target_i     redirect address, valid with flush_i
//   imem_req_o          fetch request (one-cycle pulse)
//   imem_addr_o         fetch address, valid with imem_req_o
//   imem_ready_i        response strobe
//   imem_data_i         instruction word, valid with imem_ready_i
//   pc_o                current PC register
//   IFID_pc_o           PC+4 of the instruction in IF/ID
//   IFID_inst_o         instruction in IF/ID (0 = nop when bubbled)
//   IFID_valid_o        IF/ID holds a real instruction
//   fetch_cnt_o         deliveries into IF/ID      (FETCH_PERF_CNT_EN)
//   stall_cnt_o         cycles with a hold request (FETCH_PERF_CNT_EN)
//
// Build option
//   FETCH_PERF_CNT_EN   when defined, the two perf counters are built.
//                       Otherwise both counter outputs are tied to 0.
// ---------------------------------------------------------------------------
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        PC_stall_i,
  input  logic        IFID_stall_i,
  input  logic        flush_i,
  input  logic [31:0] branch_target_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ready_i,
  input  logic [31:0] imem_data_i,
  output logic [31:0] pc_o,
  output logic [31:0] IFID_pc_o,
  output logic [31:0] IFID_inst_o,
  output logic        IFID_valid_o,
  output logic [31:0] fetch_cnt_o,
  output logic [31:0] stall_cnt_o
);

  typedef enum logic [1:0] {
    S_BOOT,
    S_ISSUE,
    S_WAIT,
    S_HOLD
  } state_t;

  state_t      state_q;
  logic [31:0] pc_q;
  logic        discard_q;     // the outstanding response belongs to a flushed path
  logic [31:0] inst_buf_q;    // response parked while the pipeline is held
  logic [31:0] ifid_pc_q;
  logic [31:0] ifid_inst_q;
  logic        ifid_valid_q;

  logic        hold;
  logic        deliver;
  logic [31:0] deliver_data;
  logic [31:0] pc_plus4;

  assign hold     = PC_stall_i | IFID_stall_i;
  assign pc_plus4 = pc_q + 32'd4;

  // A delivery moves a fresh word into IF/ID: either straight from memory
  // in WAIT or from the parked buffer in HOLD. Delivery needs hold=0, so it
  // never competes with IFID_stall_i.
  always_comb begin
    deliver      = 1'b0;
    deliver_data = imem_data_i;
    unique case (state_q)
      S_WAIT:  deliver = imem_ready_i & ~discard_q & ~flush_i & ~hold;
      S_HOLD: begin
        deliver      = ~flush_i & ~hold;
        deliver_data = inst_buf_q;
      end
      default: deliver = 1'b0;
    endcase
  end

  // Fetch control FSM and PC.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_BOOT;
      pc_q       <= RESET_PC;
      discard_q  <= 1'b0;
      inst_buf_q <= '0;
    end else begin
      unique case (state_q)
        S_BOOT: state_q <= S_ISSUE;
        S_ISSUE: begin
          state_q <= S_WAIT;
          if (flush_i) begin
            discard_q <= 1'b1;
            pc_q      <= branch_target_i;
          end
        end
        S_WAIT: begin
          if (imem_ready_i) begin
            if (discard_q || flush_i) begin
              discard_q <= 1'b0;
              if (flush_i) pc_q <= branch_target_i;
              state_q <= S_ISSUE;
            end else if (!hold) begin
              pc_q    <= pc_plus4;
              state_q <= S_ISSUE;
            end else begin
              inst_buf_q <= imem_data_i;
              state_q    <= S_HOLD;
            end
          end else if (flush_i) begin
            // The request is still in flight; the word it returns is stale.
            discard_q <= 1'b1;
            pc_q      <= branch_target_i;
          end
        end
        S_HOLD: begin
          if (flush_i) begin
            pc_q    <= branch_target_i;
            state_q <= S_ISSUE;
          end else if (!hold) begin
            pc_q    <= pc_plus4;
            state_q <= S_ISSUE;
          end
        end
        default: state_q <= S_BOOT;
      endcase
    end
  end

  // IF/ID register. Priority: flush bubble, stall hold, load, idle bubble.
  // A bubble keeps the PC field.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ifid_pc_q    <= '0;
      ifid_inst_q  <= '0;
      ifid_valid_q <= 1'b0;
    end else if (flush_i) begin
      ifid_inst_q  <= '0;
      ifid_valid_q <= 1'b0;
    end else if (IFID_stall_i) begin
      ifid_pc_q    <= ifid_pc_q;
      ifid_inst_q  <= ifid_inst_q;
      ifid_valid_q <= ifid_valid_q;
    end else if (deliver) begin
      ifid_pc_q    <= pc_plus4;
      ifid_inst_q  <= deliver_data;
      ifid_valid_q <= 1'b1;
    end else begin
      ifid_inst_q  <= '0;
      ifid_valid_q <= 1'b0;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q;
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (deliver) fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (hold)    stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign fetch_cnt_o = fetch_cnt_q;
  assign stall_cnt_o = stall_cnt_q;
`else
  assign fetch_cnt_o = '0;
  assign stall_cnt_o = '0;
`endif

  // Request outputs are decoded from registers only, so no input feeds them
  // combinationally.
  assign imem_req_o   = (state_q == S_ISSUE);
  assign imem_addr_o  = pc_q;
  assign pc_o         = pc_q;
  assign IFID_pc_o    = ifid_pc_q;
  assign IFID_inst_o  = ifid_inst_q;
  assign IFID_valid_o = ifid_valid_q;

endmodule
